arm_register_file: RTL
======================

Name: arm_register_file

Overview:
- 16 x 32-bit ARM general-purpose register file (R0-R15), R15 serving as the program counter.
- Sits directly upstream of the datapath 2-to-1 operand mux.
- rd_data_b drives the mux's register input; the mux selects between it and the immediate.
- Two combinational read ports, one synchronous write-back port, and a dedicated PC update path with increment and load.

Parameters:
- DATA_W, 32, width of every register and data port.
- PC_STEP, 4, byte increment applied to R15 on pc_inc.
- PC_RESET, 32'h00000000, value loaded into R15 on reset.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr_a  input  4  read port A register index.
- rd_addr_b  input  4  read port B register index.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_data_b  output  DATA_W  read port B data (combinational); feeds the operand mux.
- wr_en  input  1  write-back enable.
- wr_addr  input  4  write-back register index.
- wr_data  input  DATA_W  write-back data.
- pc_inc  input  1  advance R15 by PC_STEP this cycle.
- pc_ld  input  1  load R15 from pc_in this cycle (branch).
- pc_in  input  DATA_W  branch target.
- pc_out  output  DATA_W  current R15 value (registered).

Behaviour:
Reset:
- Clock and reset: single clock, clk. Reset is rst_n, asynchronous and active-low.
- While rst_n=0: R0-R14 = 0, R15 = PC_RESET, immediately and independent of clk.
- During reset: pc_out = PC_RESET; rd_data_a/b = 0 for indices 0-14 and PC_RESET for index 15.
- Reset deasserted mid-cycle: the first state change occurs at the next rising clk with rst_n=1.

Write port:
- On rising clk, wr_en=1 writes wr_data into R[wr_addr]. Latency 1 cycle to state.
- wr_en=0: no general-register change.

Read ports:
- Purely combinational from rd_addr.
- Write-first bypass: if wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle. This applies to both ports independently, including index 15.
- Both ports may read the same index simultaneously.

R15 update priority, evaluated each rising clk, highest first:
1. wr_en=1 and wr_addr=15: R15 <= wr_data.
2. pc_ld=1: R15 <= pc_in.
3. pc_inc=1: R15 <= R15 + PC_STEP, modulo 2^DATA_W (0xFFFFFFFC + 4 wraps to 0x00000000, no flag).
4. Otherwise: R15 holds.

R15 simultaneous events:
- pc_ld and pc_inc together: load wins, no increment.
- A write-back to R15 overrides both pc_ld and pc_inc.
- A write-back to R0-R14 in the same cycle as pc_inc/pc_ld: both take effect.

R15 bypass:
- The read bypass for index 15 reflects only wr_data from the write port.
- pc_ld/pc_inc effects are visible on reads and on pc_out only after the clock edge.

Other rules:
- pc_out always equals the stored R15.
- No X propagation: all storage is reset. All arithmetic is unsigned, truncated to DATA_W.

Test Plan:
1. Reset: hold rst_n=0, toggle clk -> all reads 0 for R0-R14, R15/pc_out = 0. Assert rst_n=0 asynchronously mid-cycle after writes -> values clear before the next edge.
2. Write/read: write R3=0xDEADBEEF, then rd_addr_a=3, rd_addr_b=3 -> both return 0xDEADBEEF. Write R3 again with 0x12345678 while reading R3 -> bypass returns 0x12345678 in the same cycle, state updated after the edge.
3. Operand path: write R7=0xFFFFFFFF, rd_addr_b=7 -> rd_data_b=0xFFFFFFFF while rd_data_a (addr 0) = 0. This drives the downstream mux inputs with all-ones and all-zeros.
4. PC increment: pc_inc=1 for 3 cycles from reset -> pc_out 0x4, 0x8, 0xC. Preload 0xFFFFFFFC via pc_ld, then pc_inc -> 0x00000000.
5. Priority: same cycle pc_ld=1 (pc_in=0x100), pc_inc=1 -> pc_out=0x100. Same cycle wr_en=1, wr_addr=15, wr_data=0x200, pc_ld=1 -> pc_out=0x200.
6. Concurrent: wr_en to R14=0xA5A5A5A5 with pc_inc=1 from pc=0x10 -> R14=0xA5A5A5A5 and pc_out=0x14 after one edge.

Source files
------------

// File: rtl/arm_register_file.sv
// 16 x DATA_W ARM register file: two combinational write-first read ports,
// one write-back port, and R15 doubling as the program counter.
module arm_register_file #(
   parameter int                 DATA_W   = 32,
   parameter logic [DATA_W-1:0]  PC_STEP  = DATA_W'(4),
   parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        rd_addr_a,
   input  logic [3:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [3:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pc_inc,
   input  logic              pc_ld,
   input  logic [DATA_W-1:0] pc_in,
   output logic [DATA_W-1:0] pc_out
);

   logic [15:0][DATA_W-1:0] r;
   logic                    wr_pc;

   assign wr_pc = wr_en && (wr_addr == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) r[i] <= '0;
         r[15] <= PC_RESET;
      end else begin
         for (int i = 0; i < 15; i++)
            if (wr_en && (wr_addr == 4'(i))) r[i] <= wr_data;
         // write-back beats branch load, which beats sequential increment
         if (wr_pc)       r[15] <= wr_data;
         else if (pc_ld)  r[15] <= pc_in;
         else if (pc_inc) r[15] <= r[15] + PC_STEP;
      end
   end

   // bypass only sees the write port; PC load/increment show after the edge
   assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : r[rd_addr_a];
   assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : r[rd_addr_b];
   assign pc_out    = r[15];

endmodule
